// File: rtl/ex_muldiv_alu_pkg.sv
// rtl/ex_muldiv_alu_pkg.sv - alu_ctrl code table and datapath width shared by the execute stage
package ex_muldiv_alu_pkg;

   localparam int XLEN = 32;

   localparam logic [4:0] OP_ADD   = 5'h00;
   localparam logic [4:0] OP_ADDU  = 5'h01;
   localparam logic [4:0] OP_SUB   = 5'h02;
   localparam logic [4:0] OP_SUBU  = 5'h03;
   localparam logic [4:0] OP_AND   = 5'h04;
   localparam logic [4:0] OP_OR    = 5'h05;
   localparam logic [4:0] OP_XOR   = 5'h06;
   localparam logic [4:0] OP_NOR   = 5'h07;
   localparam logic [4:0] OP_ADDI  = 5'h08;
   localparam logic [4:0] OP_ADDIU = 5'h09;
   localparam logic [4:0] OP_SLT   = 5'h0A;
   localparam logic [4:0] OP_SLTU  = 5'h0B;
   localparam logic [4:0] OP_ANDI  = 5'h0C;
   localparam logic [4:0] OP_ORI   = 5'h0D;
   localparam logic [4:0] OP_XORI  = 5'h0E;
   localparam logic [4:0] OP_LUI   = 5'h0F;
   localparam logic [4:0] OP_MFHI  = 5'h10;
   localparam logic [4:0] OP_MFLO  = 5'h12;
   localparam logic [4:0] OP_MULT  = 5'h18;
   localparam logic [4:0] OP_MULTU = 5'h19;
   localparam logic [4:0] OP_DIV   = 5'h1A;
   localparam logic [4:0] OP_DIVU  = 5'h1B;

endpackage

// File: rtl/ex_muldiv_alu_muldiv_iter.sv
// rtl/ex_muldiv_alu_muldiv_iter.sv - iterative shift-add multiplier / restoring divider with sign fix-up
module muldiv_iter #(
   parameter int W     = 32,
   parameter int STEPS = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           abort,
   input  logic           is_div,
   input  logic           is_signed,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] prod
);

   localparam int CW = $clog2(STEPS);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SETUP = ST_SETUP,
      RUN   = ST_RUN
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            op_div, op_signed;
   logic [W-1:0]    a_raw, b_raw;
   logic [W-1:0]    mag_a, mag_b_in, mag_b;
   logic [2*W-1:0]  acc, step_acc;
   logic [W+1:0]    trial;
   logic [W:0]      sum;
   logic            neg_q, neg_r, div_zero;

   // state register; abort and reset both drop back to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state and completion strobe
   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = SETUP;
         SETUP: state_nxt = abort ? IDLE : RUN;
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (cnt == CW'(STEPS - 1)) begin
               state_nxt = IDLE;
               done      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // operand magnitudes for the signed variants
   always_comb begin
      mag_a    = (op_signed && a_raw[W-1]) ? (~a_raw + 1'b1) : a_raw;
      mag_b_in = (op_signed && b_raw[W-1]) ? (~b_raw + 1'b1) : b_raw;
   end

   // one iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      trial = '0;
      sum   = '0;
      if (op_div) begin
         trial = {1'b0, acc[2*W-1:W-1]} - {2'b00, mag_b};
         if (!trial[W+1]) step_acc = {trial[W-1:0], acc[W-2:0], 1'b1};
         else             step_acc = {acc[2*W-2:W-1], acc[W-2:0], 1'b0};
      end else begin
         sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : {(W+1){1'b0}});
         step_acc = {sum, acc[W-1:1]};
      end
   end

   // operand capture, setup of magnitudes/signs, iteration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         op_div    <= 1'b0;
         op_signed <= 1'b0;
         a_raw     <= '0;
         b_raw     <= '0;
         mag_b     <= '0;
         acc       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_div    <= is_div;
                  op_signed <= is_signed;
                  a_raw     <= a;
                  b_raw     <= b;
               end
            end
            SETUP: begin
               mag_b    <= mag_b_in;
               acc      <= {{W{1'b0}}, mag_a};
               cnt      <= '0;
               neg_q    <= op_signed & (a_raw[W-1] ^ b_raw[W-1]);
               neg_r    <= op_signed & a_raw[W-1];
               div_zero <= op_div & (b_raw == '0);
            end
            RUN: begin
               acc <= step_acc;
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // sign fix-up of the final iteration; divide by zero returns raw dividend and all-ones
   always_comb begin
      if (!op_div) begin
         prod = neg_q ? (~step_acc + 1'b1) : step_acc;
      end else if (div_zero) begin
         prod = {a_raw, {W{1'b1}}};
      end else begin
         prod[2*W-1:W] = neg_r ? (~step_acc[2*W-1:W] + 1'b1) : step_acc[2*W-1:W];
         prod[W-1:0]   = neg_q ? (~step_acc[W-1:0] + 1'b1) : step_acc[W-1:0];
      end
   end

endmodule

// File: rtl/ex_muldiv_alu.sv
// rtl/ex_muldiv_alu.sv - execute-stage ALU with HI/LO and iterative mul/div; EX_FAST_MUL_EN selects a single-cycle multiplier
module ex_muldiv_alu #(
   parameter int XLEN  = ex_muldiv_alu_pkg::XLEN,
   parameter int STEPS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_ctrl,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            flush,
   output logic            out_valid,
   output logic [XLEN-1:0] result,
   output logic            overflow,
   output logic            busy,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   import ex_muldiv_alu_pkg::*;

   logic              rst_done;
   logic              accept, is_mul, is_div, eng_start;
   logic              eng_busy, eng_done;
   logic [2*XLEN-1:0] eng_prod;
   logic [XLEN-1:0]   sum, diff, alu_res;
   logic              alu_ovf;

   assign is_mul   = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_MULTU);
   assign is_div   = (alu_ctrl == OP_DIV)  || (alu_ctrl == OP_DIVU);
   assign in_ready = rst_done & ~eng_busy;
   assign accept   = in_valid & in_ready & ~flush;
   assign busy     = eng_busy;

`ifdef EX_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign eng_start = accept & is_div;

   // full-width product, truncation to 2*XLEN is exact for both signednesses
   always_comb begin
      if (alu_ctrl == OP_MULT)
         fast_prod = $signed({{XLEN{src_a[XLEN-1]}}, src_a}) * $signed({{XLEN{src_b[XLEN-1]}}, src_b});
      else
         fast_prod = {{XLEN{1'b0}}, src_a} * {{XLEN{1'b0}}, src_b};
   end
`else
   assign eng_start = accept & (is_mul | is_div);
`endif

   muldiv_iter #(
      .W     (XLEN),
      .STEPS (STEPS)
   ) u_muldiv (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (eng_start),
      .abort     (flush),
      .is_div    (is_div),
      .is_signed ((alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV)),
      .a         (src_a),
      .b         (src_b),
      .busy      (eng_busy),
      .done      (eng_done),
      .prod      (eng_prod)
   );

   // single-cycle result and signed overflow for ADD/ADDI/SUB
   always_comb begin
      sum     = src_a + src_b;
      diff    = src_a - src_b;
      alu_res = '0;
      alu_ovf = 1'b0;
      case (alu_ctrl)
         OP_ADD, OP_ADDI: begin
            alu_res = sum;
            alu_ovf = (src_a[XLEN-1] == src_b[XLEN-1]) && (sum[XLEN-1] != src_a[XLEN-1]);
         end
         OP_ADDU, OP_ADDIU: alu_res = sum;
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (src_a[XLEN-1] != src_b[XLEN-1]) && (diff[XLEN-1] != src_a[XLEN-1]);
         end
         OP_SUBU:         alu_res = diff;
         OP_AND, OP_ANDI: alu_res = src_a & src_b;
         OP_OR,  OP_ORI:  alu_res = src_a | src_b;
         OP_XOR, OP_XORI: alu_res = src_a ^ src_b;
         OP_NOR:          alu_res = ~(src_a | src_b);
         OP_SLT:          alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         OP_SLTU:         alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
         OP_LUI:          alu_res = src_b << 16;
         OP_MFHI:         alu_res = hi;
         OP_MFLO:         alu_res = lo;
         default:         alu_res = '0;
      endcase
   end

   // in_ready stays low until the first clock after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_done <= 1'b0;
      else        rst_done <= 1'b1;
   end

   // result/HI/LO registers and the one-cycle completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         out_valid <= 1'b0;
         if (eng_done) begin
            hi        <= eng_prod[2*XLEN-1:XLEN];
            lo        <= eng_prod[XLEN-1:0];
            result    <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
`ifdef EX_FAST_MUL_EN
         end else if (accept && is_mul) begin
            hi        <= fast_prod[2*XLEN-1:XLEN];
            lo        <= fast_prod[XLEN-1:0];
            result    <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
`endif
         end else if (accept && !is_mul && !is_div) begin
            result    <= alu_res;
            overflow  <= alu_ovf;
            out_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_alu.sv
// tb/tb_ex_muldiv_alu.sv - scoreboard bench for ex_muldiv_alu with a behavioural reference model
module tb_ex_muldiv_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  alu_ctrl;
   logic [31:0] src_a, src_b;
   logic        flush;
   logic        out_valid;
   logic [31:0] result;
   logic        overflow;
   logic        busy;
   logic [31:0] hi, lo;

   ex_muldiv_alu #(.XLEN(32), .STEPS(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .src_a     (src_a),
      .src_b     (src_b),
      .flush     (flush),
      .out_valid (out_valid),
      .result    (result),
      .overflow  (overflow),
      .busy      (busy),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] m_hi     = 0;
   logic [31:0] m_lo     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit is_fast_mul(input logic [4:0] c);
`ifdef EX_FAST_MUL_EN
      return (c == 5'h18) || (c == 5'h19);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit is_multi(input logic [4:0] c);
      return (c >= 5'h18) && (c <= 5'h1B) && !is_fast_mul(c);
   endfunction

   // reference model: architectural effect of one instruction on result/overflow/HI/LO
   task automatic model_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, output exp_t e);
      int          sa, sb;
      longint      wide;
      logic [63:0] p;
      sa    = $signed(a);
      sb    = $signed(b);
      e.res = 0;
      e.ovf = 0;
      case (c)
         5'h00, 5'h08: begin
            wide  = longint'(sa) + longint'(sb);
            e.res = a + b;
            e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         5'h01, 5'h09: e.res = a + b;
         5'h02: begin
            wide  = longint'(sa) - longint'(sb);
            e.res = a - b;
            e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         5'h03:        e.res = a - b;
         5'h04, 5'h0C: e.res = a & b;
         5'h05, 5'h0D: e.res = a | b;
         5'h06, 5'h0E: e.res = a ^ b;
         5'h07:        e.res = ~(a | b);
         5'h0A:        e.res = (sa < sb) ? 1 : 0;
         5'h0B:        e.res = (a < b) ? 1 : 0;
         5'h0F:        e.res = {b[15:0], 16'h0000};
         5'h10:        e.res = m_hi;
         5'h12:        e.res = m_lo;
         5'h18: begin
            wide = longint'(sa) * longint'(sb);
            p    = wide;
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         5'h19: begin
            p    = {32'h0, a} * {32'h0, b};
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         5'h1A: begin
            if (b == 0) begin
               m_lo = 32'hFFFFFFFF;
               m_hi = a;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               m_lo = 32'h80000000;
               m_hi = 0;
            end else begin
               m_lo = sa / sb;
               m_hi = sa % sb;
            end
         end
         5'h1B: begin
            if (b == 0) begin
               m_lo = 32'hFFFFFFFF;
               m_hi = a;
            end else begin
               m_lo = a / b;
               m_hi = a % b;
            end
         end
         default: e.res = 0;
      endcase
      e.hi = m_hi;
      e.lo = m_lo;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 200 && in_ready !== 1'b1; i++) @(negedge clk);
      if (in_ready !== 1'b1) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
   endtask

   // issue one instruction from a negedge; expected response goes to the scoreboard
   task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      wait_ready();
      model_op(c, a, b, e);
      e.cyc    = cyc + 1 + (is_multi(c) ? 33 : 0);
      sb_q.push_back(e);
      in_valid = 1'b1;
      alu_ctrl = c;
      src_a    = a;
      src_b    = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (is_multi(c)) begin
         for (int i = 0; i < 33; i++) begin
            check("busy_in_ready_while_running", {62'd0, busy, in_ready}, 64'd2);
            @(negedge clk);
         end
      end else if (is_fast_mul(c)) begin
         check("fast_mul_busy", {63'd0, busy}, 64'd0);
      end
   endtask

   // start a MULTU 5*5 that will be cut short; nothing is expected from it
   task automatic start_unscored();
      wait_ready();
      in_valid = 1'b1;
      alu_ctrl = 5'h19;
      src_a    = 5;
      src_b    = 5;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // monitor: every out_valid pulse must match the oldest expected response
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_out_valid", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result",   {32'd0, result},   {32'd0, e.res});
            check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
            check("hi",       {32'd0, hi},       {32'd0, e.hi});
            check("lo",       {32'd0, lo},       {32'd0, e.lo});
            check("latency",  64'(cyc),          64'(e.cyc));
         end
      end
   end

   logic [31:0] specials[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
   logic [4:0]  codes[25]   = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
                                5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h12,
                                5'h18, 5'h19, 5'h1A, 5'h1B, 5'h11, 5'h1F, 5'h14};

   function automatic logic [31:0] rand_operand();
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) return $urandom_range(0, 20);
      return $urandom;
   endfunction

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      flush    = 1'b0;
      alu_ctrl = 0;
      src_a    = 0;
      src_b    = 0;
      repeat (3) @(negedge clk);
      check("reset_in_ready",  {63'd0, in_ready},  64'd0);
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_busy",      {63'd0, busy},      64'd0);
      check("reset_result",    {32'd0, result},    64'd0);
      check("reset_hilo",      {hi, lo},           64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_release", {63'd0, in_ready}, 64'd1);

      // flush at RUN counter 10: engine abandons, HI/LO untouched, no completion
      start_unscored();
      repeat (11) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_in_ready", {63'd0, in_ready}, 64'd1);
      check("flush_busy",     {63'd0, busy},     64'd0);
      check("flush_hilo",     {hi, lo},          64'd0);
      repeat (40) @(negedge clk);
      check("flush_hilo_later", {hi, lo}, 64'd0);

      // flush together with in_valid drops the input
      in_valid = 1'b1;
      flush    = 1'b1;
      alu_ctrl = 5'h00;
      src_a    = 1;
      src_b    = 2;
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      check("flushed_input_dropped", {62'd0, out_valid, busy}, 64'd0);

      // directed cases
      issue(5'h00, 32'h7FFFFFFF, 32'h1);
      issue(5'h01, 32'h7FFFFFFF, 32'h1);
      issue(5'h02, 32'h80000000, 32'h1);
      issue(5'h0A, 32'hFFFFFFFF, 32'h1);
      issue(5'h0B, 32'hFFFFFFFF, 32'h1);
      issue(5'h0F, 32'h0, 32'h1234);
      issue(5'h18, 32'hFFFFFFFD, 32'h7);
      issue(5'h12, 32'h0, 32'h0);
      issue(5'h10, 32'h0, 32'h0);
      issue(5'h1A, 32'hFFFFFFF9, 32'h2);
      issue(5'h1B, 32'd10, 32'h0);
      issue(5'h1A, 32'h80000000, 32'hFFFFFFFF);
      issue(5'h1A, 32'hFFFFFFF9, 32'h0);
      issue(5'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);

      // reset pulse mid-operation aborts at once
      start_unscored();
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_flags", {60'd0, out_valid, busy, in_ready, overflow}, 64'd0);
      check("midreset_result", {32'd0, result}, 64'd0);
      check("midreset_hilo", {hi, lo}, 64'd0);
      m_hi = 0;
      m_lo = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midreset_in_ready_after", {63'd0, in_ready}, 64'd1);

      // randomized mix, including undefined codes and divide-by-zero
      for (int i = 0; i < 60; i++) begin
         issue(codes[$urandom_range(0, 24)], rand_operand(), rand_operand());
      end

      for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(negedge clk);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_alu.md
Name: ex_muldiv_alu

Overview:
- Execute-stage datapath that consumes the 5-bit alu_ctrl code produced by the ALU-control decoder, together with the ID/EX operands.
- Single-cycle ops (arithmetic, logic, compare, LUI, MFHI/MFLO) return a registered result in 1 clock.
- MULT/MULTU/DIV/DIVU run on an iterative 32-step engine that updates the architectural HI/LO registers.
- Back-pressures the pipeline through in_ready/busy while the engine is running.

Parameters:
- XLEN, 32, operand/result width; only 32 is verified.
- STEPS, 32, iterations per multiply/divide; must equal XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX presents an instruction
- in_ready  out  1  block accepts input this cycle
- alu_ctrl  in  5  operation code from ALU-control decoder
- src_a  in  XLEN  rs operand (forwarded)
- src_b  in  XLEN  rt operand or extended immediate (forwarded)
- flush  in  1  squash instruction in flight (branch/exception)
- out_valid  out  1  one-cycle pulse: result/HI/LO update complete
- result  out  XLEN  registered result
- overflow  out  1  signed overflow on ADD/SUB/ADDI, qualified by out_valid
- busy  out  1  multiply/divide engine active
- hi  out  XLEN  architectural HI
- lo  out  XLEN  architectural LO

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_valid=0, result=0, overflow=0, busy=0, hi=0, lo=0, counter=0, in_ready=0 while reset is asserted. in_ready=1 from the first clock after release.
- Accept rule: an input is accepted at an edge where in_valid & in_ready & ~flush. in_ready = (state==IDLE).
- Codes, single-cycle:
  - 0x00 ADD, 0x08 ADDI: a+b with signed overflow.
  - 0x01 ADDU, 0x09 ADDIU: a+b, no overflow.
  - 0x02 SUB: a-b with overflow.
  - 0x03 SUBU: a-b, no overflow.
  - 0x04/0x0C AND; 0x05/0x0D OR; 0x06/0x0E XOR; 0x07 NOR.
  - 0x0A SLT/SLTI: signed compare. 0x0B SLTU/SLTIU: unsigned compare. Compare result is zero-extended 0/1.
  - 0x0F LUI: b<<16.
  - 0x10 MFHI: hi. 0x12 MFLO: lo.
  - Any other code: result=0, overflow=0.
- Single-cycle latency: accepted at edge E0 -> result/overflow/out_valid visible after E0. out_valid falls after E1 unless a new op is accepted.
- Overflow: result still carries the wrapped sum. overflow=1 only for 0x00/0x08/0x02 when operand and result signs violate two's-complement rules.
- Codes, multi-cycle: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
- FSM IDLE -> SETUP -> RUN -> IDLE:
  - SETUP: latch magnitudes for signed ops and record result signs; busy=1.
  - RUN: 32 iterations, counter 0..31. Multiply is shift-add; divide is restoring. Exit when counter==31.
  - Edge E33 (33 edges after accept E0): write sign-corrected hi/lo, out_valid=1, result=0, state IDLE. in_ready=1 in the same cycle.
  - busy=1 from after E0 through E33.
- Multiply: {hi,lo}=64-bit product; signed product negated when operand signs differ.
- Divide: lo=quotient, hi=remainder. Remainder takes the dividend's sign; quotient is negated when signs differ.
- Divide by zero: lo=32'hFFFFFFFF, hi=src_a (raw), both signed and unsigned. No trap.
- Signed 0x80000000 / -1: lo=0x80000000, hi=0.
- MFHI/MFLO cannot issue while busy (in_ready=0), so they never read stale HI/LO.
- flush: in SETUP/RUN returns to IDLE next edge; hi/lo unchanged, no out_valid. flush together with in_valid: input dropped. flush in IDLE has no effect on held outputs except forcing out_valid=0.
- Reset mid-operation: immediate abort to reset values.

Optional Feature:
- Macro EX_FAST_MUL_EN.
- Defined: MULT/MULTU complete like single-cycle ops. The 64-bit product is computed combinationally and registered at E0, so out_valid, hi and lo update after E0 and busy stays 0. DIV/DIVU are unchanged.
- Undefined: iterative 33-edge multiply as specified above.

Decomposition:
- Shared package/include (existing asm_table): the alu_ctrl code constants above, plus XLEN.
- FSM state encoding lives as localparams in this block.
- One natural sub-module: muldiv_iter, which contains the SETUP/RUN engine, counter and sign fix-up. It has start/done/abort ports and outputs a 64-bit result.

Test Plan:
- ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1. ADDU with the same operands -> overflow=0. out_valid 1 cycle after accept.
- SLT -1 vs 1 -> 1. SLTU -1 vs 1 -> 0. LUI b=0x1234 -> 0x12340000.
- MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. out_valid exactly 33 edges after accept, in_ready=0 and busy=1 throughout. Then MFLO -> 0xFFFFFFEB.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 10/0 -> lo=0xFFFFFFFF, hi=10. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Start MULTU 5*5 with hi/lo=0, then flush at RUN counter 10 -> no out_valid, hi/lo stay 0, in_ready=1 next cycle. Repeat the sequence with rst_n pulsed low instead of flush -> all outputs 0 immediately.
- With EX_FAST_MUL_EN, MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1 one cycle after accept, busy never asserts.
